// File: rtl/fifo_word_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_word_packer_if
// Brief    : FIFO read-port and packed-word output bundle for fifo_word_packer.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_word_packer_if #(
    parameter int WIDTH = 8,
    parameter int PACK  = 4
);
    localparam int OUT_WIDTH = WIDTH * PACK;
    localparam int CNT_WIDTH = $clog2(PACK + 1);

    logic                 fifo_empty_i;
    logic [WIDTH-1:0]     fifo_rdata_i;
    logic                 fifo_rd_en_o;
    logic                 flush_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [OUT_WIDTH-1:0] out_data_o;
    logic [CNT_WIDTH-1:0] out_count_o;
    logic                 busy_o;

    modport master (
        input  fifo_empty_i, fifo_rdata_i, flush_i, out_ready_i,
        output fifo_rd_en_o, out_valid_o, out_data_o, out_count_o, busy_o
    );

    modport slave (
        output fifo_empty_i, fifo_rdata_i, flush_i, out_ready_i,
        input  fifo_rd_en_o, out_valid_o, out_data_o, out_count_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/fifo_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_word_packer
// Brief    : Drains a byte FIFO and packs PACK entries per valid/ready word.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_word_packer #(
    parameter int WIDTH = 8,
    parameter int PACK  = 4
) (
    input  wire logic            clk_i,
    input  wire logic            rst_i,
    fifo_word_packer_if.master   bus
);
    localparam int OUT_WIDTH = WIDTH * PACK;
    localparam int CNT_WIDTH = $clog2(PACK + 1);
    localparam logic [CNT_WIDTH-1:0] c_pack_cnt = CNT_WIDTH'(PACK);
    localparam logic [CNT_WIDTH:0]   c_pack_ext = (CNT_WIDTH + 1)'(PACK);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t               state_q,      state_d;
    logic [CNT_WIDTH-1:0] lane_cnt_q,   lane_cnt_d;
    logic                 rd_pend_q,    rd_pend_d;
    logic                 flush_pend_q, flush_pend_d;
    logic                 out_valid_q,  out_valid_d;
    logic [CNT_WIDTH-1:0] out_count_q,  out_count_d;
    logic [OUT_WIDTH-1:0] data_q,       data_d;

    logic                 w_pop;
    logic [CNT_WIDTH:0]   w_occ;
    logic [CNT_WIDTH-1:0] w_cnt_inc;

    always_comb begin
        state_d      = state_q;
        lane_cnt_d   = lane_cnt_q;
        flush_pend_d = flush_pend_q | bus.flush_i;
        out_valid_d  = out_valid_q;
        out_count_d  = out_count_q;
        data_d       = data_q;

        // Lanes held plus the entry still in flight must leave room for one more.
        w_occ     = {1'b0, lane_cnt_q} + {{CNT_WIDTH{1'b0}}, rd_pend_q};
        w_pop     = (state_q == ST_FILL) && !bus.fifo_empty_i && !flush_pend_q
                    && (w_occ < c_pack_ext) && !rst_i;
        w_cnt_inc = lane_cnt_q + CNT_WIDTH'(1);
        rd_pend_d = w_pop;

        case (state_q)
            ST_FILL: begin
                if (rd_pend_q) begin
                    for (int k = 0; k < PACK; k++) begin
                        if (lane_cnt_q == CNT_WIDTH'(k)) begin
                            data_d[k*WIDTH +: WIDTH] = bus.fifo_rdata_i;
                        end
                    end
                    lane_cnt_d = w_cnt_inc;
                    if (w_cnt_inc == c_pack_cnt) begin
                        state_d     = ST_HOLD;
                        out_valid_d = 1'b1;
                        out_count_d = c_pack_cnt;
                        if (flush_pend_q) begin
                            flush_pend_d = bus.flush_i;
                        end
                    end
                end else if (flush_pend_q) begin
                    flush_pend_d = bus.flush_i;
                    if (lane_cnt_q != '0) begin
                        state_d     = ST_HOLD;
                        out_valid_d = 1'b1;
                        out_count_d = lane_cnt_q;
                    end
                end
            end
            ST_HOLD: begin
                // Pending flush survives the accept and is judged against empty lanes.
                if (bus.out_ready_i) begin
                    state_d     = ST_FILL;
                    out_valid_d = 1'b0;
                    out_count_d = '0;
                    lane_cnt_d  = '0;
                    data_d      = '0;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_FILL;
            lane_cnt_q   <= '0;
            rd_pend_q    <= 1'b0;
            flush_pend_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_count_q  <= '0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            lane_cnt_q   <= lane_cnt_d;
            rd_pend_q    <= rd_pend_d;
            flush_pend_q <= flush_pend_d;
            out_valid_q  <= out_valid_d;
            out_count_q  <= out_count_d;
            data_q       <= data_d;
        end
    end

    assign bus.fifo_rd_en_o = w_pop;
    assign bus.out_valid_o  = out_valid_q;
    assign bus.out_data_o   = data_q;
    assign bus.out_count_o  = out_count_q;
    assign bus.busy_o       = (lane_cnt_q != '0) | rd_pend_q | flush_pend_q | out_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_fifo_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_word_packer
// Brief    : Directed bench for fifo_word_packer with a FIFO model and word scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_word_packer;
    localparam int WIDTH = 8;
    localparam int PACK  = 4;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  cnt;
    } word_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_word_packer_if #(.WIDTH(WIDTH), .PACK(PACK)) bus ();

    fifo_word_packer #(.WIDTH(WIDTH), .PACK(PACK)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] pend_q[$];
    logic [7:0] fq[$];
    word_t      exp_q[$];
    logic [7:0] rdata_m = 8'h00;
    logic       empty_m = 1'b1;
    int         rd_cnt = 0;
    int         underflow = 0;
    int         hold_pop = 0;
    int         valid_cyc = 0;

    assign bus.fifo_rdata_i = rdata_m;
    assign bus.fifo_empty_i = empty_m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // syn_fifo stand-in: registered read data, writes visible after the next edge
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fq.delete();
            pend_q.delete();
            rdata_m <= 8'h00;
            empty_m <= 1'b1;
        end else begin
            if (bus.fifo_rd_en_o) begin
                rd_cnt++;
                if (bus.out_valid_o) hold_pop++;
                if (fq.size() == 0) underflow++;
                else rdata_m <= fq.pop_front();
            end
            while (pend_q.size() != 0) fq.push_back(pend_q.pop_front());
            empty_m <= (fq.size() == 0);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid_o) valid_cyc++;
            if (bus.out_valid_o && bus.out_ready_i) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_extra_word observed=%0h expected=none", bus.out_data_o);
                end
                if (exp_q.size() != 0) begin
                    word_t e;
                    e = exp_q.pop_front();
                    chk("sb_word_data", 64'(bus.out_data_o), 64'(e.data));
                    chk("sb_word_count", 64'(bus.out_count_o), 64'(e.cnt));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_bytes(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3, input int n);
        logic [7:0] arr [4];
        arr[0] = b0; arr[1] = b1; arr[2] = b2; arr[3] = b3;
        for (int i = 0; i < n; i++) pend_q.push_back(arr[i]);
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [2:0] c);
        word_t e;
        e.data = d;
        e.cnt  = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
        repeat (2) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0, v0, h0, n;
        rst = 1'b1;
        bus.out_ready_i = 1'b0;
        bus.flush_i     = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 64'(bus.out_valid_o), 64'd0);
        chk("rst_data",  64'(bus.out_data_o),  64'd0);
        chk("rst_count", 64'(bus.out_count_o), 64'd0);
        chk("rst_busy",  64'(bus.busy_o),      64'd0);
        chk("rst_rd_en", 64'(bus.fifo_rd_en_o), 64'd0);
        rst = 1'b0;
        tick();

        // full word with consumer always ready
        bus.out_ready_i = 1'b1;
        r0 = rd_cnt; v0 = valid_cyc;
        expect_word(32'h44332211, 3'd4);
        push_bytes(8'h11, 8'h22, 8'h33, 8'h44, 4);
        wait_drain("t1_drain", 40);
        chk("t1_pops", 64'(rd_cnt - r0), 64'd4);
        chk("t1_valid_cycles", 64'(valid_cyc - v0), 64'd1);

        // back-pressure: first word must sit still, no pops while held
        bus.out_ready_i = 1'b0;
        r0 = rd_cnt; h0 = hold_pop;
        expect_word(32'h88776655, 3'd4);
        expect_word(32'hCCBBAA99, 3'd4);
        push_bytes(8'h55, 8'h66, 8'h77, 8'h88, 4);
        push_bytes(8'h99, 8'hAA, 8'hBB, 8'hCC, 4);
        repeat (7) tick();
        chk("t2_valid", 64'(bus.out_valid_o), 64'd1);
        chk("t2_data_a", 64'(bus.out_data_o), 64'h88776655);
        repeat (3) tick();
        chk("t2_data_b", 64'(bus.out_data_o), 64'h88776655);
        chk("t2_count", 64'(bus.out_count_o), 64'd4);
        chk("t2_pops_held", 64'(rd_cnt - r0), 64'd4);
        chk("t2_hold_pops", 64'(hold_pop - h0), 64'd0);
        bus.out_ready_i = 1'b1;
        wait_drain("t2_drain", 40);
        chk("t2_pops_total", 64'(rd_cnt - r0), 64'd8);

        // flush of a two-lane partial word
        expect_word(32'h0000BBAA, 3'd2);
        push_bytes(8'hAA, 8'hBB, 8'h00, 8'h00, 2);
        repeat (6) tick();
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        wait_drain("t3_drain", 40);

        // flush coincident with the third pop stops the fourth
        bus.out_ready_i = 1'b0;
        r0 = rd_cnt;
        expect_word(32'h00030201, 3'd3);
        push_bytes(8'h01, 8'h02, 8'h03, 8'h04, 4);
        n = 0;
        for (int i = 0; i < 20 && n < 3; i++) begin
            tick();
            if (bus.fifo_rd_en_o) begin
                n++;
                if (n == 3) bus.flush_i = 1'b1;
            end
        end
        tick();
        bus.flush_i = 1'b0;
        repeat (4) tick();
        chk("t4_valid", 64'(bus.out_valid_o), 64'd1);
        chk("t4_pops", 64'(rd_cnt - r0), 64'd3);
        chk("t4_count", 64'(bus.out_count_o), 64'd3);
        expect_word(32'h00000004, 3'd1);
        bus.out_ready_i = 1'b1;
        repeat (6) tick();
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        wait_drain("t4_drain", 40);

        // empty FIFO with repeated flushes: nothing moves
        r0 = rd_cnt; v0 = valid_cyc;
        for (int i = 0; i < 20; i++) begin
            bus.flush_i = (i % 4 == 0);
            tick();
        end
        bus.flush_i = 1'b0;
        repeat (2) tick();
        chk("t5_pops", 64'(rd_cnt - r0), 64'd0);
        chk("t5_valid", 64'(valid_cyc - v0), 64'd0);
        chk("t5_underflow", 64'(underflow), 64'd0);
        chk("t5_busy", 64'(bus.busy_o), 64'd0);

        // asynchronous reset with three lanes held
        push_bytes(8'h01, 8'h02, 8'h03, 8'h00, 3);
        repeat (6) tick();
        chk("t6_busy_before", 64'(bus.busy_o), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(bus.out_valid_o), 64'd0);
        chk("t6_rst_data",  64'(bus.out_data_o),  64'd0);
        chk("t6_rst_count", 64'(bus.out_count_o), 64'd0);
        chk("t6_rst_busy",  64'(bus.busy_o),      64'd0);
        chk("t6_rst_rd_en", 64'(bus.fifo_rd_en_o), 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        expect_word(32'h04030201, 3'd4);
        push_bytes(8'h01, 8'h02, 8'h03, 8'h04, 4);
        wait_drain("t6_drain", 40);
        chk("final_underflow", 64'(underflow), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
